// File: rtl/term_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : term_pkg
//  Purpose  : Shared widths, FSM state encoding and the slot-packing helper
//             for the term encoder feeding the term-quantized MAC array.
//  Revision : 1.0  initial release
// ============================================================================
package term_pkg;

   localparam int DATA_WIDTH         = 8;
   localparam int NUM_COMBINED_TERMS = 8;
   localparam int NUM_BIT_EXPONENT   = 3;
   localparam int MAX_GROUP          = 16;

   localparam int SIZE_W             = 5;
   localparam int BUDGET_W           = 7;
   localparam int TERMS_W            = 4;

   typedef enum logic [1:0] {
      LOAD = 2'd0,
      SCAN = 2'd1,
      EMIT = 2'd2
   } state_e;

   // Slot that bit position 'pos' of 'mask' lands in when the kept bits are
   // packed in descending order: the count of kept bits above it.
   function automatic logic [TERMS_W-1:0] slot_of(input logic [DATA_WIDTH-1:0] mask,
                                                  input int pos);
      logic [TERMS_W-1:0] n;
      n = '0;
      for (int b = 0; b < DATA_WIDTH; b++) begin
         if ((b > pos) && mask[b]) begin
            n = n + 4'd1;
         end
      end
      return n;
   endfunction

endpackage
`default_nettype wire

// File: rtl/term_pack.sv
`default_nettype none
// ============================================================================
//  Module   : term_pack
//  Purpose  : Combinational packer. Turns a keep-mask plus sign into the
//             descending exponent slots, per-slot signs and a term count.
//  Revision : 1.0  initial release
// ============================================================================
module term_pack #(
   parameter int DATA_WIDTH         = 8,
   parameter int NUM_COMBINED_TERMS = 8,
   parameter int NUM_BIT_EXPONENT   = 3
) (
   input  logic [DATA_WIDTH-1:0]                          keep_i,
   input  logic                                           sign_i,
   output logic [NUM_BIT_EXPONENT*NUM_COMBINED_TERMS-1:0] exponent_o,
   output logic [NUM_COMBINED_TERMS-1:0]                  sign_o,
   output logic [3:0]                                     terms_o
);
   import term_pkg::*;

   logic [NUM_BIT_EXPONENT-1:0] slot;

   // Place each kept bit in its descending-order slot; unused slots stay zero.
   always_comb begin
      exponent_o = '0;
      sign_o     = '0;
      terms_o    = '0;
      slot       = '0;
      for (int e = DATA_WIDTH - 1; e >= 0; e--) begin
         if (keep_i[e]) begin
            slot = NUM_BIT_EXPONENT'(slot_of(keep_i, e));
            exponent_o[int'(slot)*NUM_BIT_EXPONENT +: NUM_BIT_EXPONENT] = NUM_BIT_EXPONENT'(e);
            sign_o[slot] = sign_i;
            terms_o      = terms_o + 4'd1;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/term_encoder.sv
`default_nettype none
// ============================================================================
//  Module   : term_encoder
//  Purpose  : Buffers a group of signed activations, keeps only the
//             group_budget largest power-of-two terms across the group
//             (MSB-first scan, ties to lowest index) and emits one packed
//             beat per value for the MAC array.
//  Revision : 1.0  initial release
// ============================================================================
module term_encoder #(
   parameter int DATA_WIDTH         = term_pkg::DATA_WIDTH,
   parameter int MAX_GROUP          = term_pkg::MAX_GROUP,
   parameter int NUM_COMBINED_TERMS = term_pkg::NUM_COMBINED_TERMS,
   parameter int NUM_BIT_EXPONENT   = term_pkg::NUM_BIT_EXPONENT
) (
   input  logic                                           clk,
   input  logic                                           reset,
   input  logic                                           in_valid,
   output logic                                           in_ready,
   input  logic [DATA_WIDTH-1:0]                          in_data,
   input  logic [4:0]                                     group_size,
   input  logic [6:0]                                     group_budget,
   output logic                                           out_valid,
   input  logic                                           out_ready,
   output logic [NUM_BIT_EXPONENT*NUM_COMBINED_TERMS-1:0] out_exponent,
   output logic [NUM_COMBINED_TERMS-1:0]                  out_sign,
   output logic [3:0]                                     out_terms,
   output logic                                           out_last
);
   import term_pkg::*;

   localparam int IDX_W = $clog2(MAX_GROUP);
   localparam int CNT_W = $clog2(MAX_GROUP + 1);
   localparam int EXP_W = NUM_BIT_EXPONENT * NUM_COMBINED_TERMS;

   state_e                      state_q;
   logic [IDX_W-1:0]            idx_q;
   logic [IDX_W-1:0]            last_q;
   logic [BUDGET_W-1:0]         budget_q;
   logic [BUDGET_W-1:0]         rem_q;
   logic [NUM_BIT_EXPONENT-1:0] bit_q;
   logic [DATA_WIDTH-1:0]       mag_q  [MAX_GROUP];
   logic [DATA_WIDTH-1:0]       keep_q [MAX_GROUP];
   logic [MAX_GROUP-1:0]        sign_q;

   logic                        in_ready_q;
   logic                        out_valid_q;
   logic [EXP_W-1:0]            out_exponent_q;
   logic [NUM_COMBINED_TERMS-1:0] out_sign_q;
   logic [3:0]                  out_terms_q;
   logic                        out_last_q;

   logic [DATA_WIDTH-1:0]       in_mag;
   logic [IDX_W-1:0]            size_last;
   logic [IDX_W-1:0]            last_d;
   logic [BUDGET_W-1:0]         budget_d;
   logic [MAX_GROUP-1:0]        hit;
   logic [MAX_GROUP-1:0]        keep_bit;
   logic [CNT_W-1:0]            cnt;
   logic [CNT_W-1:0]            prefix;
   logic                        take_all;
   logic [DATA_WIDTH-1:0]       keep_d [MAX_GROUP];
   logic [BUDGET_W-1:0]         rem_d;
   logic [IDX_W-1:0]            next_idx;
   logic [DATA_WIDTH-1:0]       pack_keep;
   logic                        pack_sign;
   logic [EXP_W-1:0]            pack_exponent;
   logic [NUM_COMBINED_TERMS-1:0] pack_sign_vec;
   logic [3:0]                  pack_terms;

   // Two's-complement magnitude; -128 wraps to 0x80, which reads as 128 unsigned.
   assign in_mag   = in_data[DATA_WIDTH-1] ? (~in_data + 1'b1) : in_data;
   assign next_idx = idx_q + 1'b1;

   // Group geometry: clamp size to 1..MAX_GROUP, take live inputs only on idx 0.
   always_comb begin
      if (group_size == 5'd0) begin
         size_last = '0;
      end else if (int'(group_size) > MAX_GROUP) begin
         size_last = IDX_W'(MAX_GROUP - 1);
      end else begin
         size_last = IDX_W'(group_size - 5'd1);
      end
      last_d   = (idx_q == '0) ? size_last    : last_q;
      budget_d = (idx_q == '0) ? group_budget : budget_q;
   end

   // One bit-plane of term revealing: keep all set bits if the budget allows,
   // otherwise only the lowest-index ones until the budget is spent.
   always_comb begin
      hit      = '0;
      keep_bit = '0;
      cnt      = '0;
      prefix   = '0;
      for (int j = 0; j < MAX_GROUP; j++) begin
         hit[j] = mag_q[j][bit_q] && (IDX_W'(j) <= last_q);
         cnt    = cnt + CNT_W'(hit[j]);
      end
      take_all = (BUDGET_W'(cnt) <= rem_q);
      for (int j = 0; j < MAX_GROUP; j++) begin
         keep_bit[j] = hit[j] && (take_all || (BUDGET_W'(prefix) < rem_q));
         keep_d[j]   = keep_q[j] | (DATA_WIDTH'(keep_bit[j]) << bit_q);
         prefix      = prefix + CNT_W'(hit[j]);
      end
      rem_d = take_all ? (rem_q - BUDGET_W'(cnt)) : '0;
   end

   // Beat 0 is packed from the mask being finished on the last scan cycle;
   // later beats pack the next buffered value ahead of its handshake.
   always_comb begin
      if (state_q == SCAN) begin
         pack_keep = keep_d[0];
         pack_sign = sign_q[0];
      end else begin
         pack_keep = keep_q[next_idx];
         pack_sign = sign_q[next_idx];
      end
   end

   term_pack #(
      .DATA_WIDTH         (DATA_WIDTH),
      .NUM_COMBINED_TERMS (NUM_COMBINED_TERMS),
      .NUM_BIT_EXPONENT   (NUM_BIT_EXPONENT)
   ) u_pack (
      .keep_i     (pack_keep),
      .sign_i     (pack_sign),
      .exponent_o (pack_exponent),
      .sign_o     (pack_sign_vec),
      .terms_o    (pack_terms)
   );

   // Group FSM with buffers and registered output beat.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q        <= LOAD;
         idx_q          <= '0;
         last_q         <= '0;
         budget_q       <= '0;
         rem_q          <= '0;
         bit_q          <= '0;
         sign_q         <= '0;
         in_ready_q     <= 1'b1;
         out_valid_q    <= 1'b0;
         out_exponent_q <= '0;
         out_sign_q     <= '0;
         out_terms_q    <= '0;
         out_last_q     <= 1'b0;
         for (int j = 0; j < MAX_GROUP; j++) begin
            mag_q[j]  <= '0;
            keep_q[j] <= '0;
         end
      end else begin
         case (state_q)
            LOAD: begin
               if (in_valid && in_ready_q) begin
                  mag_q[idx_q]  <= in_mag;
                  sign_q[idx_q] <= in_data[DATA_WIDTH-1];
                  if (idx_q == '0) begin
                     last_q   <= size_last;
                     budget_q <= group_budget;
                  end
                  if (idx_q == last_d) begin
                     state_q    <= SCAN;
                     idx_q      <= '0;
                     in_ready_q <= 1'b0;
                     rem_q      <= budget_d;
                     bit_q      <= NUM_BIT_EXPONENT'(DATA_WIDTH - 1);
                     for (int j = 0; j < MAX_GROUP; j++) begin
                        keep_q[j] <= '0;
                     end
                  end else begin
                     idx_q <= next_idx;
                  end
               end
            end
            SCAN: begin
               for (int j = 0; j < MAX_GROUP; j++) begin
                  keep_q[j] <= keep_d[j];
               end
               rem_q <= rem_d;
               if (bit_q == '0) begin
                  state_q        <= EMIT;
                  idx_q          <= '0;
                  out_valid_q    <= 1'b1;
                  out_exponent_q <= pack_exponent;
                  out_sign_q     <= pack_sign_vec;
                  out_terms_q    <= pack_terms;
                  out_last_q     <= (last_q == '0);
               end else begin
                  bit_q <= bit_q - 1'b1;
               end
            end
            EMIT: begin
               if (out_ready) begin
                  if (out_last_q) begin
                     state_q        <= LOAD;
                     idx_q          <= '0;
                     in_ready_q     <= 1'b1;
                     out_valid_q    <= 1'b0;
                     out_exponent_q <= '0;
                     out_sign_q     <= '0;
                     out_terms_q    <= '0;
                     out_last_q     <= 1'b0;
                  end else begin
                     idx_q          <= next_idx;
                     out_exponent_q <= pack_exponent;
                     out_sign_q     <= pack_sign_vec;
                     out_terms_q    <= pack_terms;
                     out_last_q     <= (next_idx == last_q);
                  end
               end
            end
            default: begin
               state_q <= LOAD;
            end
         endcase
      end
   end

   assign in_ready     = in_ready_q;
   assign out_valid    = out_valid_q;
   assign out_exponent = out_exponent_q;
   assign out_sign     = out_sign_q;
   assign out_terms    = out_terms_q;
   assign out_last     = out_last_q;

endmodule
`default_nettype wire

// File: tb/tb_term_encoder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_term_encoder
//  Purpose  : Directed self-checking bench for term_encoder.
//  Revision : 1.0  initial release
// ============================================================================
module tb_term_encoder;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [7:0]  in_data = '0;
   logic [4:0]  group_size = '0;
   logic [6:0]  group_budget = '0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [23:0] out_exponent;
   logic [7:0]  out_sign;
   logic [3:0]  out_terms;
   logic        out_last;

   int checks = 0;
   int errors = 0;

   term_encoder dut (
      .clk          (clk),
      .reset        (reset),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_data      (in_data),
      .group_size   (group_size),
      .group_budget (group_budget),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_exponent (out_exponent),
      .out_sign     (out_sign),
      .out_terms    (out_terms),
      .out_last     (out_last)
   );

   always #5 clk = ~clk;

   // Observed beat: {valid, last, terms, sign, exponent}
   logic [37:0] obs;
   assign obs = {out_valid, out_last, out_terms, out_sign, out_exponent};

   function automatic logic [37:0] beat(input logic v, input logic l, input logic [3:0] t,
                                        input logic [7:0] s, input logic [23:0] e);
      return {v, l, t, s, e};
   endfunction

   // Present one value and hold it until it is accepted; returns at edge+1.
   task automatic send(input logic [7:0] v, input logic [4:0] sz, input logic [6:0] bud,
                       output bit to);
      int n;
      n = 0;
      in_valid = 1'b1; in_data = v; group_size = sz; group_budget = bud;
      while (!in_ready && n < 100) begin
         @(posedge clk); #1; n++;
      end
      to = (n >= 100);
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic wait_valid(output int edges, output bit to);
      edges = 0;
      while (!out_valid && edges < 60) begin
         @(posedge clk); #1; edges++;
      end
      to = !out_valid;
   endtask

   task automatic test_reset;
      reset = 1'b1;
      repeat (3) @(posedge clk);
      #1; reset = 1'b0;
      checks++;
      if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b expected 1", in_ready); end
      checks++;
      if (obs !== 38'd0) begin errors++; $display("FAIL reset_outputs got %h expected %h", obs, 38'd0); end
   endtask

   task automatic test_basic;
      bit to; int edges;
      send(8'd7, 5'd2, 7'd3, to);
      send(8'hFB, 5'd9, 7'd0, to);   // later size/budget changes must be ignored
      wait_valid(edges, to);
      checks++;
      if (to || edges != 8) begin errors++; $display("FAIL basic_latency got %0d edges expected 8", edges); end
      checks++;
      if (obs !== beat(1'b1, 1'b0, 4'd2, 8'h00, 24'h00000A)) begin
         errors++; $display("FAIL basic_beat0 got %h expected %h", obs, beat(1'b1, 1'b0, 4'd2, 8'h00, 24'h00000A));
      end
      @(posedge clk); #1;
      checks++;
      if (obs !== beat(1'b1, 1'b1, 4'd1, 8'h01, 24'h000002)) begin
         errors++; $display("FAIL basic_beat1 got %h expected %h", obs, beat(1'b1, 1'b1, 4'd1, 8'h01, 24'h000002));
      end
      @(posedge clk); #1;
      checks++;
      if ({out_valid, in_ready} !== 2'b01) begin errors++; $display("FAIL basic_done got %b expected 01", {out_valid, in_ready}); end
   endtask

   task automatic test_ties;
      bit to; int edges;
      logic [3:0] et [4];
      et[0] = 4'd1; et[1] = 4'd1; et[2] = 4'd0; et[3] = 4'd0;
      for (int i = 0; i < 4; i++) send(8'd1, 5'd4, 7'd2, to);
      wait_valid(edges, to);
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (obs !== beat(1'b1, i == 3, et[i], 8'h00, 24'h0)) begin
            errors++; $display("FAIL ties_beat%0d got %h expected %h", i, obs, beat(1'b1, i == 3, et[i], 8'h00, 24'h0));
         end
         @(posedge clk); #1;
      end
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL ties_count got valid %b expected 0", out_valid); end
   endtask

   task automatic test_full_range;
      bit to; int edges;
      send(8'h80, 5'd1, 7'd127, to);
      wait_valid(edges, to);
      checks++;
      if (obs !== beat(1'b1, 1'b1, 4'd1, 8'h01, 24'h000007)) begin
         errors++; $display("FAIL neg128 got %h expected %h", obs, beat(1'b1, 1'b1, 4'd1, 8'h01, 24'h000007));
      end
      @(posedge clk); #1;
      send(8'h55, 5'd0, 7'd127, to);  // size 0 behaves as 1
      wait_valid(edges, to);
      checks++;
      if (obs !== beat(1'b1, 1'b1, 4'd4, 8'h00, 24'h0000A6)) begin
         errors++; $display("FAIL val55 got %h expected %h", obs, beat(1'b1, 1'b1, 4'd4, 8'h00, 24'h0000A6));
      end
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL size0_single got valid %b expected 0", out_valid); end
   endtask

   task automatic test_zero_budget;
      bit to; int edges;
      logic [7:0] v [3];
      v[0] = 8'd3; v[1] = 8'd9; v[2] = 8'd12;
      for (int i = 0; i < 3; i++) send(v[i], 5'd3, 7'd0, to);
      wait_valid(edges, to);
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (obs !== beat(1'b1, i == 2, 4'd0, 8'h00, 24'h0)) begin
            errors++; $display("FAIL zero_budget_beat%0d got %h expected %h", i, obs, beat(1'b1, i == 2, 4'd0, 8'h00, 24'h0));
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_max_group;
      bit to; int edges; int n;
      logic [7:0]  j8;
      logic [23:0] ee;
      for (int j = 0; j < 16; j++) send(8'(j), 5'd31, 7'd127, to);  // 31 clamps to 16
      wait_valid(edges, to);
      for (int j = 0; j < 16; j++) begin
         j8 = 8'(j); ee = '0; n = 0;
         for (int b = 7; b >= 0; b--) if (j8[b]) begin ee[n*3 +: 3] = 3'(b); n++; end
         checks++;
         if (obs !== beat(1'b1, j == 15, 4'(n), 8'h00, ee)) begin
            errors++; $display("FAIL max_group_beat%0d got %h expected %h", j, obs, beat(1'b1, j == 15, 4'(n), 8'h00, ee));
         end
         @(posedge clk); #1;
      end
      checks++;
      if ({out_valid, in_ready} !== 2'b01) begin errors++; $display("FAIL max_group_done got %b expected 01", {out_valid, in_ready}); end
   endtask

   task automatic test_backpressure;
      bit to; int edges;
      out_ready = 1'b0;
      send(8'd3,  5'd3, 7'd127, to);
      send(8'hFA, 5'd3, 7'd127, to);
      send(8'd9,  5'd3, 7'd127, to);
      wait_valid(edges, to);
      @(posedge clk); #1;
      checks++;
      if (obs !== beat(1'b1, 1'b0, 4'd2, 8'h00, 24'h000001)) begin
         errors++; $display("FAIL bp_beat0 got %h expected %h", obs, beat(1'b1, 1'b0, 4'd2, 8'h00, 24'h000001));
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      for (int c = 0; c < 3; c++) begin
         checks++;
         if (obs !== beat(1'b1, 1'b0, 4'd2, 8'h03, 24'h00000A)) begin
            errors++; $display("FAIL bp_hold%0d got %h expected %h", c, obs, beat(1'b1, 1'b0, 4'd2, 8'h03, 24'h00000A));
         end
         @(posedge clk); #1;
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (obs !== beat(1'b1, 1'b1, 4'd2, 8'h00, 24'h000003)) begin
         errors++; $display("FAIL bp_beat2 got %h expected %h", obs, beat(1'b1, 1'b1, 4'd2, 8'h00, 24'h000003));
      end
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_done got valid %b expected 0", out_valid); end
   endtask

   task automatic test_reset_mid_scan;
      bit to; int edges;
      send(8'd1, 5'd2, 7'd5, to);
      send(8'd2, 5'd2, 7'd5, to);
      repeat (3) @(posedge clk);
      #1; reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      checks++;
      if ({in_ready, out_valid, out_terms} !== 6'b10_0000) begin
         errors++; $display("FAIL midscan_reset got %b expected 100000", {in_ready, out_valid, out_terms});
      end
      send(8'd6, 5'd1, 7'd1, to);
      wait_valid(edges, to);
      checks++;
      if (to || edges != 8) begin errors++; $display("FAIL midscan_latency got %0d edges expected 8", edges); end
      checks++;
      if (obs !== beat(1'b1, 1'b1, 4'd1, 8'h00, 24'h000002)) begin
         errors++; $display("FAIL midscan_beat got %h expected %h", obs, beat(1'b1, 1'b1, 4'd1, 8'h00, 24'h000002));
      end
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL midscan_done got valid %b expected 0", out_valid); end
   endtask

   initial begin
      test_reset;
      test_basic;
      test_ties;
      test_full_range;
      test_zero_budget;
      test_max_group;
      test_backpressure;
      test_reset_mid_scan;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
